// File: rtl/ureg_cmd_sequencer.sv
// Command sequencer for the universal register: a FIFO of {op,data,count} commands,
// each issued on ctrl/D for count+1 cycles. Optional abort port under UREG_SEQ_ABORT_EN.
module ureg_cmd_sequencer #(
  parameter int N     = 4,
  parameter int CW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef UREG_SEQ_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [N-1:0]             cmd_data,
  input  logic [CW-1:0]            cmd_count,
  output logic [2:0]               ctrl,
  output logic [N-1:0]             D,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [2:0]    op;
    logic [N-1:0]  data;
    logic [CW-1:0] count;
  } cmd_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rem;
  state_t        state_q, state_d;
  logic          kill, empty, full, push, pop, last;
  cmd_t          head;

`ifdef UREG_SEQ_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign empty     = (fifo_level == '0);
  assign full      = (fifo_level == LW'(DEPTH));
  assign cmd_ready = !rst && !kill && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign last      = (state_q == ISSUE) && (rem == '0);
  assign busy      = (state_q == ISSUE);

  // Pop on the edge that ends the current command so the next op follows with no bubble.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rem == '0) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || kill) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, data: cmd_data, count: cmd_count};
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      ctrl <= '0;
      D    <= '0;
      rem  <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (pop) begin
        ctrl <= head.op;
        D    <= head.data;
        rem  <= head.count;
      end else if (state_q == ISSUE && rem != '0) begin
        rem <= rem - 1'b1;
      end else if (state_d == IDLE) begin
        ctrl <= '0;
        D    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ureg_cmd_sequencer.sv
// Self-checking bench for ureg_cmd_sequencer: each accepted command is scheduled
// as an issue window [start, start+count] on an edge timeline and outputs are derived from it.
module tb_ureg_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_count;
  logic [2:0] ctrl;
  logic [3:0] D;
  logic       busy;
  logic       done;
  logic [2:0] fifo_level;
`ifdef UREG_SEQ_ABORT_EN
  logic       abort;
`endif

  ureg_cmd_sequencer #(.N(4), .CW(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef UREG_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .ctrl       (ctrl),
    .D          (D),
    .busy       (busy),
    .done       (done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         a;    // accept edge
    int         s;    // pop edge; issued after edges s..s+cnt
    int         cnt;
    logic [2:0] op;
    logic [3:0] data;
  } rec_t;

  rec_t        sched[$];
  int          k = 0;
  int          last_end = -1;
  int          checks = 0;
  int          failures = 0;
  logic        obs_ready, exp_ready;
  logic [11:0] obs, exp;
  logic [2:0]  e_lvl = 3'd0;

  // One cycle: drive inputs at negedge, sample ready, advance the schedule, sample outputs.
  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] dt,
                       input logic [3:0] cnt, input logic r, input logic ab);
    logic [2:0] ec;
    logic [3:0] ed;
    logic       eb, edn;
    int         lvl, s;
    @(negedge clk);
    cmd_valid = v; cmd_op = op; cmd_data = dt; cmd_count = cnt; rst = r;
`ifdef UREG_SEQ_ABORT_EN
    abort = ab;
`endif
    #1;
    obs_ready = cmd_ready;
    exp_ready = !r && !ab && (e_lvl < 3'd4);
    @(posedge clk);
    k++;
    if (r || ab) begin
      sched.delete();
      last_end = -1;
    end else if (v && exp_ready) begin
      s = (k + 1 > last_end + 1) ? k + 1 : last_end + 1;
      sched.push_back('{a: k, s: s, cnt: int'(cnt), op: op, data: dt});
      last_end = s + int'(cnt);
    end
    #1;
    ec = 3'd0; ed = 4'd0; eb = 1'b0; edn = 1'b0; lvl = 0;
    foreach (sched[i]) begin
      if (sched[i].s <= k && k <= sched[i].s + sched[i].cnt) begin
        ec = sched[i].op; ed = sched[i].data; eb = 1'b1;
      end
      if (sched[i].s + sched[i].cnt + 1 == k) edn = 1'b1;
      if (sched[i].a <= k && sched[i].s > k) lvl++;
    end
    e_lvl = 3'(lvl);
    exp = {ec, ed, eb, edn, e_lvl};
    obs = {ctrl, D, busy, done, fifo_level};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd3, 4'h5, 4'd2, 1'b1, 1'b0);
      checks += 2;
      if (obs_ready !== 1'b0) begin
        failures++; $display("FAIL reset_ready cyc=%0d got=%b want=0", k, obs_ready);
      end
      if (obs !== 12'h000) begin
        failures++; $display("FAIL reset_outputs cyc=%0d got=%h want=000", k, obs);
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b1, 3'd1, 4'hA, 4'd0, 1'b0, 1'b0);
      else        drive(1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0);
      checks += 2;
      if (obs_ready !== exp_ready) begin
        failures++; $display("FAIL single_ready cyc=%0d got=%b want=%b", k, obs_ready, exp_ready);
      end
      if (obs !== exp) begin
        failures++; $display("FAIL single_out cyc=%0d got=%h want=%h", k, obs, exp);
      end
      if (i == 1) begin
        checks++;
        if (ctrl !== 3'd1 || D !== 4'hA || busy !== 1'b1) begin
          failures++; $display("FAIL single_load ctrl=%0d D=%h busy=%b want 1 A 1", ctrl, D, busy);
        end
      end
    end
  endtask

  task automatic run_script(input string name, input int n, input logic [2:0] op,
                            input logic [3:0] cnt, input int nv);
    for (int i = 0; i < n; i++) begin
      drive(i < nv, op, 4'h3 + 4'(i), cnt, 1'b0, 1'b0);
      checks += 2;
      if (obs_ready !== exp_ready) begin
        failures++; $display("FAIL %s_ready cyc=%0d got=%b want=%b", name, k, obs_ready, exp_ready);
      end
      if (obs !== exp) begin
        failures++; $display("FAIL %s_out cyc=%0d got=%h want=%h", name, k, obs, exp);
      end
    end
  endtask

  task automatic test_repeat();    run_script("repeat", 8, 3'd2, 4'd3, 1);   endtask
  task automatic test_fill();      run_script("fill", 48, 3'd0, 4'd7, 8);    endtask
  task automatic test_max_count(); run_script("maxcnt", 20, 3'd6, 4'd15, 1); endtask

  task automatic test_back_to_back();
    logic [2:0] seen[$];
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive(1'b1, 3'd4, 4'h1, 4'd1, 1'b0, 1'b0);
      else if (i == 1) drive(1'b1, 3'd5, 4'h2, 4'd0, 1'b0, 1'b0);
      else             drive(1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL b2b_out cyc=%0d got=%h want=%h", k, obs, exp);
      end
      if (i >= 1) seen.push_back(ctrl);
    end
    checks++;
    if (seen[0] !== 3'd4 || seen[1] !== 3'd4 || seen[2] !== 3'd5 || seen[3] !== 3'd0) begin
      failures++;
      $display("FAIL b2b_seq got=%0d,%0d,%0d,%0d want=4,4,5,0", seen[0], seen[1], seen[2], seen[3]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      drive(i < 4, 3'd7, 4'h9, 4'd3, i == 4, 1'b0);
      checks += 2;
      if (obs_ready !== exp_ready) begin
        failures++; $display("FAIL rstmid_ready cyc=%0d got=%b want=%b", k, obs_ready, exp_ready);
      end
      if (obs !== exp) begin
        failures++; $display("FAIL rstmid_out cyc=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

`ifdef UREG_SEQ_ABORT_EN
  task automatic test_abort();
    for (int i = 0; i < 10; i++) begin
      drive(i < 3 || i == 4, 3'd2, 4'hC, 4'd3, 1'b0, i == 4);
      checks += 2;
      if (obs_ready !== exp_ready) begin
        failures++; $display("FAIL abort_ready cyc=%0d got=%b want=%b", k, obs_ready, exp_ready);
      end
      if (obs !== exp) begin
        failures++; $display("FAIL abort_out cyc=%0d got=%h want=%h", k, obs, exp);
      end
    end
    abort = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 4'($urandom),
            c, $urandom_range(0, 79) == 0, 1'b0);
      checks += 2;
      if (obs_ready !== exp_ready) begin
        failures++; $display("FAIL random_ready cyc=%0d got=%b want=%b", k, obs_ready, exp_ready);
      end
      if (obs !== exp) begin
        failures++; $display("FAIL random_out cyc=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
`ifdef UREG_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_single();
    test_repeat();
    test_fill();
    test_back_to_back();
    test_reset_mid();
`ifdef UREG_SEQ_ABORT_EN
    test_abort();
`endif
    test_max_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ureg_cmd_sequencer.md
Name: ureg_cmd_sequencer

Overview:
- Upstream command stage for the universal register.
- Accepts queued operation commands over a valid/ready handshake, buffers them in a small FIFO, and drives the register's 3-bit control code and parallel-load data.
- Each command runs its operation for a programmable number of consecutive cycles; when no command is active, the control output is hold (code 0).

Parameters:
N, 4, data width; matches the register's n
CW, 4, repeat-count field width
DEPTH, 4, FIFO depth in commands; power of 2, minimum 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  3  operation code 0..7; register encoding
cmd_data  in  N  load value; meaningful for op 1
cmd_count  in  CW  repeat count; op is issued cmd_count+1 cycles
ctrl  out  3  control code to register, registered
D  out  N  parallel data to register, registered
busy  out  1  a command is being issued
done  out  1  one-cycle pulse after a command's last issue cycle
fifo_level  out  $clog2(DEPTH)+1  commands stored

Behaviour:
- Reset (rst high at a clk edge) forces the following, regardless of state:
  - FIFO flushed, fifo_level=0.
  - FSM goes to IDLE.
  - ctrl=0, D=0, busy=0, done=0.
  - In-flight and queued commands are discarded.
- cmd_ready = !rst && (fifo_level < DEPTH); combinational.
- Push occurs when cmd_valid && cmd_ready at a clk edge; {op,data,count} is stored.
- FIFO full: cmd_ready=0. A same-cycle pop does not re-enable the push; there is no write-through when full.
- Push and pop at the same edge when not full: fifo_level unchanged.
- FSM states: IDLE, ISSUE. A remaining-cycles counter `rem` is CW bits wide.
- IDLE:
  - ctrl=0, D=0, busy=0.
  - If FIFO non-empty at an edge: pop head, load ctrl=op, D=data, rem=count, go to ISSUE.
- ISSUE:
  - busy=1; ctrl and D stay constant for the whole command.
  - At each edge with rem>0: rem decrements.
  - At the edge with rem==0, the command ends and done=1 in the following cycle only.
  - If the FIFO is non-empty at that edge, the next command is popped and its op appears in the very next cycle; no bubble, FSM stays in ISSUE.
  - Otherwise the FSM goes to IDLE with ctrl=0, D=0.
- Latency: a command pushed into an empty FIFO while IDLE at edge E0 is popped at E1; its ctrl is visible after E1.
- cmd_count=max (2^CW-1) issues 2^CW cycles; the counter must not wrap or overflow.
- Op 0 is legal: it issues hold for count+1 cycles, i.e. a timed delay.
- All op codes 0..7 pass through unmodified. D is driven with cmd_data for every op; the register ignores it except for op 1.
- FIFO pointers wrap modulo DEPTH; fifo_level distinguishes full from empty.

Optional Feature:
- Macro: UREG_SEQ_ABORT_EN.
- When defined, the block adds input port `abort` (1 bit).
- abort high at an edge:
  - FIFO flushed, FSM to IDLE, ctrl=0, D=0, busy=0.
  - No done pulse for the aborted command.
  - cmd_ready is forced 0 while abort is high, so a same-cycle push is dropped.
- Reset has priority over abort.
- When not defined, the port is absent and behaviour is exactly as above.

Test Plan:
1. Reset, then push op=1 data=4'hA count=0 at E0 -> ctrl=1, D=4'hA for exactly one cycle after E1; done=1 the next cycle; then ctrl=0, D=0, busy=0.
2. Push op=2 count=3 -> ctrl=2 for 4 consecutive cycles with busy=1; attached register loaded to 4'hA reads 4'hE afterwards; one done pulse.
3. Hold cmd_valid for 8 cycles with op=0 count=7 each -> 5 commands accepted (edges E0..E4); fifo_level reaches 4; cmd_ready low from then until the first command finishes.
4. Queue op=4 count=1 then op=5 count=0 -> ctrl sequence 4,4,5,0 with no gap cycle; done pulses in the cycle of the first 5 and in the cycle of the first 0.
5. Queue 3 commands, assert rst for one cycle mid-ISSUE -> next cycle ctrl=0, D=0, busy=0, fifo_level=0; no queued command ever issued; cmd_ready=0 during rst.
6. (UREG_SEQ_ABORT_EN) abort mid-ISSUE with 2 queued and cmd_valid high -> ctrl=0 next cycle, fifo_level=0, no done, offered command not accepted.
